// File: rtl/wb_write_arbiter_pkg.sv
// Shared register-file constants for the writeback arbiter.
// Imported by the interface, the aux queue and the arbiter top.
package wb_write_arbiter_pkg;

    localparam int RegBusW     = 32;
    localparam int RegAddrBusW = 5;
    localparam int AuxQDepth   = 2;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic RstEnable    = 1'b1;

    localparam logic [RegBusW-1:0] ZeroWord = '0;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between the result sources, decode and the register-file
// write port; master drives results and read checks, slave is the arbiter.
interface wb_write_arbiter_if
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RegBusW,
    parameter int ADDR_W = RegAddrBusW,
    parameter int DEPTH  = AuxQDepth
) ();

    logic                     pipe_we;
    logic [ADDR_W-1:0]        pipe_waddr;
    logic [DATA_W-1:0]        pipe_wdata;

    logic                     aux_valid;
    logic                     aux_ready;
    logic [ADDR_W-1:0]        aux_waddr;
    logic [DATA_W-1:0]        aux_wdata;

    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;

    logic [ADDR_W-1:0]        chk_addr1;
    logic [ADDR_W-1:0]        chk_addr2;
    logic                     hazard1;
    logic                     hazard2;

    logic [$clog2(DEPTH):0]   q_count;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output aux_valid, aux_waddr, aux_wdata,
        output chk_addr1, chk_addr2,
        input  aux_ready, we, waddr, wdata,
        input  hazard1, hazard2, q_count
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  aux_valid, aux_waddr, aux_wdata,
        input  chk_addr1, chk_addr2,
        output aux_ready, we, waddr, wdata,
        output hazard1, hazard2, q_count
    );

endinterface

// File: rtl/wb_aux_fifo.sv
// Small FIFO holding auxiliary results until the write port is free.
// Exposes every entry's address and valid bit for hazard compares.
module wb_aux_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RegBusW,
    parameter int ADDR_W = RegAddrBusW,
    parameter int DEPTH  = AuxQDepth
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_addr,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [ADDR_W-1:0]             head_addr,
    output logic [DATA_W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_mem;
    logic [DATA_W-1:0]            data_mem [DEPTH];
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [DEPTH-1:0]             valid;

    // Entry payload; never reset since the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // The arbiter must never push into a full or pop an empty queue.
    always_ff @(posedge clk) begin
        if (rst != RstEnable) begin
            assert (!(push && count == FULL));
            assert (!(pop && count == '0));
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign ent_valid = valid;
    assign ent_addr  = addr_mem;

endmodule

// File: rtl/wb_write_arbiter.sv
// Single register-file write port shared by the pipeline writeback
// (never stalled) and a queued long-latency auxiliary result source.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RegBusW,
    parameter int ADDR_W = RegAddrBusW,
    parameter int DEPTH  = AuxQDepth
) (
    input  logic               clk,
    input  logic               rst,
    wb_write_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic                         pipe_real;
    logic                         aux_hs;
    logic                         aux_real;
    logic                         q_empty;
    logic                         pop;
    logic                         push;
    logic                         bypass;
    logic [CNT_W-1:0]             count;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;

    // Ready depends only on the stored count; reset masks it so no
    // handshake can complete while the queue is being flushed.
    assign bus.aux_ready = (rst != RstEnable) && (count < FULL);
    assign bus.q_count   = count;

    // Port selection: pipeline, then queue head, then direct bypass.
    always_comb begin
        pipe_real = bus.pipe_we && (bus.pipe_waddr != '0);
        aux_hs    = bus.aux_valid && bus.aux_ready;
        aux_real  = aux_hs && (bus.aux_waddr != '0);
        q_empty   = (count == '0);
        pop       = !pipe_real && !q_empty;
        bypass    = !pipe_real && q_empty && aux_real;
        push      = aux_real && !bypass;
    end

    wb_aux_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (bus.aux_waddr),
        .push_data (bus.aux_wdata),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (count),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    // Registered write port; address/data hold when no write is selected.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            bus.we    <= WriteDisable;
            bus.waddr <= '0;
            bus.wdata <= DATA_W'(ZeroWord);
        end else if (pipe_real) begin
            bus.we    <= WriteEnable;
            bus.waddr <= bus.pipe_waddr;
            bus.wdata <= bus.pipe_wdata;
        end else if (pop) begin
            bus.we    <= WriteEnable;
            bus.waddr <= head_addr;
            bus.wdata <= head_data;
        end else if (bypass) begin
            bus.we    <= WriteEnable;
            bus.waddr <= bus.aux_waddr;
            bus.wdata <= bus.aux_wdata;
        end else begin
            bus.we    <= WriteDisable;
        end
    end

    // Decode read hazards against queued destinations only.
    always_comb begin
        bus.hazard1 = 1'b0;
        bus.hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_addr[i] == bus.chk_addr1)
                bus.hazard1 = 1'b1;
            if (ent_valid[i] && ent_addr[i] == bus.chk_addr2)
                bus.hazard2 = 1'b1;
        end
        if (bus.chk_addr1 == '0) bus.hazard1 = 1'b0;
        if (bus.chk_addr2 == '0) bus.hazard2 = 1'b0;
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_wb_write_arbiter;
    import wb_write_arbiter_pkg::*;

    localparam int DEPTH = AuxQDepth;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    wb_write_arbiter_if bus ();

    wb_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t        q[$];
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    int          nchecks = 0;
    int          nerrors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit in_q(input logic [4:0] a);
        foreach (q[i]) if (q[i].a == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit haz(input logic [4:0] a);
        return (a != 0) && in_q(a);
    endfunction

    // One clock: drive, check combinational outputs, advance model,
    // then check the registered write port after the edge.
    task automatic cycle(input bit r, input bit pwe, input logic [4:0] pa,
                         input logic [31:0] pd, input bit av,
                         input logic [4:0] aa, input logic [31:0] ad,
                         input logic [4:0] c1, input logic [4:0] c2,
                         output bit hs);
        bit   rdy;
        ent_t e;
        @(negedge clk);
        rst            = r;
        bus.pipe_we    = pwe;
        bus.pipe_waddr = pa;
        bus.pipe_wdata = pd;
        bus.aux_valid  = av;
        bus.aux_waddr  = aa;
        bus.aux_wdata  = ad;
        bus.chk_addr1  = c1;
        bus.chk_addr2  = c2;
        #1;
        rdy = !r && (q.size() < DEPTH);
        check("aux_ready", bus.aux_ready, rdy);
        check("q_count", bus.q_count, q.size());
        check("hazard1", bus.hazard1, haz(c1));
        check("hazard2", bus.hazard2, haz(c2));
        hs = av && rdy;
        if (r) begin
            q.delete();
            ewe = 0; ea = 0; ed = 0;
        end else if (pwe && pa != 0) begin
            check("contract", in_q(pa), 1'b0);
            ewe = 1; ea = pa; ed = pd;
            if (hs && aa != 0) q.push_back('{aa, ad});
        end else if (q.size() > 0) begin
            e = q.pop_front();
            ewe = 1; ea = e.a; ed = e.d;
            if (hs && aa != 0) q.push_back('{aa, ad});
        end else if (hs && aa != 0) begin
            ewe = 1; ea = aa; ed = ad;
        end else begin
            ewe = 0;
        end
        @(posedge clk);
        #1;
        check("we", bus.we, ewe);
        check("waddr", bus.waddr, ea);
        check("wdata", bus.wdata, ed);
    endtask

    task automatic idle(input bit r = 0, input logic [4:0] c1 = 0);
        bit hs;
        cycle(r, 0, 0, 0, 0, 0, 0, c1, 0, hs);
    endtask

    initial begin
        bit          hs;
        int          k;
        logic [4:0]  bpa[3];
        logic [31:0] bpd[3];
        bit          pav;
        logic [4:0]  paa, pa, c1, c2;
        logic [31:0] pad;
        bit          r, pwe;

        bus.pipe_we = 0; bus.pipe_waddr = 0; bus.pipe_wdata = 0;
        bus.aux_valid = 0; bus.aux_waddr = 0; bus.aux_wdata = 0;
        bus.chk_addr1 = 0; bus.chk_addr2 = 0;
        ewe = 0; ea = 0; ed = 0;
        repeat (2) @(posedge clk);

        // reset, idle, and reset with a loaded queue
        idle(1);
        idle(0);
        idle(0);
        cycle(0, 1, 1, 32'h100, 1, 10, 32'hA0, 0, 0, hs);
        cycle(0, 1, 2, 32'h200, 1, 11, 32'hA1, 10, 11, hs);
        check("rst_prefill", bus.q_count, 2);
        idle(1, 10);
        check("rst_flush", bus.q_count, 0);
        repeat (3) idle(0, 10);

        // bypass path
        cycle(0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0, hs);
        check("byp_we", bus.we, 1'b1);
        check("byp_waddr", bus.waddr, 5'd7);
        check("byp_wdata", bus.wdata, 32'hDEADBEEF);
        check("byp_q", bus.q_count, 0);

        // contention with the pipeline
        cycle(0, 1, 3, 32'h11, 1, 9, 32'h22, 9, 0, hs);
        check("cont_q", bus.q_count, 1);
        check("cont_h1", bus.hazard1, 1'b1);
        idle(0, 9);
        check("cont_waddr", bus.waddr, 5'd9);
        check("cont_h1_clr", bus.hazard1, 1'b0);

        // back-pressure while the pipeline owns the port
        bpa = '{5'd4, 5'd5, 5'd6};
        bpd = '{32'hA, 32'hB, 32'hC};
        k = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 5'(20 + i), 32'(i), k < 3, bpa[k % 3], bpd[k % 3],
                  4, 6, hs);
            if (hs) k++;
        end
        check("bp_accepted", k, 2);
        for (int i = 0; i < 10 && k < 3; i++) begin
            cycle(0, 0, 0, 0, 1, bpa[k], bpd[k], 5, 6, hs);
            if (hs) k++;
        end
        check("bp_done", k, 3);
        repeat (2) idle(0);

        // address zero on both sources
        cycle(0, 1, 3, 32'h33, 1, 8, 32'h88, 0, 0, hs);
        cycle(0, 1, 0, 32'h99, 0, 0, 0, 8, 0, hs);
        check("az_waddr", bus.waddr, 5'd8);
        check("az_wdata", bus.wdata, 32'h88);
        cycle(0, 0, 0, 0, 1, 0, 32'h77, 0, 0, hs);
        check("az_hs", hs, 1'b1);
        check("az_we", bus.we, 1'b0);
        check("az_q", bus.q_count, 0);

        // full queue pops but refuses in the same cycle
        cycle(0, 1, 12, 32'h1, 1, 13, 32'hC3, 0, 0, hs);
        cycle(0, 1, 14, 32'h2, 1, 15, 32'hC5, 0, 0, hs);
        cycle(0, 0, 0, 0, 1, 16, 32'hC6, 0, 0, hs);
        check("full_hs", hs, 1'b0);
        check("full_rdy_next", bus.aux_ready, 1'b1);
        cycle(0, 0, 0, 0, 1, 16, 32'hC6, 16, 15, hs);
        check("full_hs_next", hs, 1'b1);
        repeat (3) idle(0);

        // random traffic
        pav = 0; paa = 0; pad = 0;
        for (int n = 0; n < 800; n++) begin
            r   = ($urandom_range(99) == 0);
            pwe = ($urandom_range(1) == 0);
            pa  = 5'($urandom_range(15, 1));
            for (int t = 0; t < 32 && in_q(pa); t++)
                pa = 5'($urandom_range(15, 1));
            if ($urandom_range(7) == 0) pa = 0;
            if (!pav && $urandom_range(2) == 0) begin
                pav = 1;
                paa = 5'($urandom_range(15));
                pad = $urandom;
            end
            c1 = 5'($urandom_range(15));
            c2 = (q.size() > 0) ? q[0].a : 5'($urandom_range(15));
            cycle(r, pwe, pa, $urandom, pav, paa, pad, c1, c2, hs);
            if (hs) pav = 0;
        end
        repeat (4) idle(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Single writer in front of the register file's one write port.
- Merges two result sources:
  - the in-order pipeline writeback, which is never stalled;
  - a long-latency auxiliary unit, such as the divider or a late load return, using a valid/ready handshake.
- Auxiliary results are buffered in a small queue and written only in cycles the pipeline leaves the port idle.
- Exposes pending-write hazard flags to decode so that reads of queued destinations stall.

Parameters:
- DATA_W, 32, register data width (matches RegBus).
- ADDR_W, 5, register address width (matches RegAddrBus).
- DEPTH, 2, auxiliary queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pipe_we  in  1  pipeline result valid this cycle
- pipe_waddr  in  ADDR_W  pipeline destination
- pipe_wdata  in  DATA_W  pipeline result
- aux_valid  in  1  auxiliary result offered
- aux_ready  out  1  queue can accept
- aux_waddr  in  ADDR_W  auxiliary destination
- aux_wdata  in  DATA_W  auxiliary result
- we  out  1  register file write enable
- waddr  out  ADDR_W  register file write address
- wdata  out  DATA_W  register file write data
- chk_addr1  in  ADDR_W  decode read address 1
- chk_addr2  in  ADDR_W  decode read address 2
- hazard1  out  1  chk_addr1 has a pending auxiliary write
- hazard2  out  1  chk_addr2 has a pending auxiliary write
- q_count  out  clog2(DEPTH)+1  current queue occupancy

Behaviour:
- **Reset:** while rst=1 at a clock edge, all of the following are zero: we, waddr, wdata, the queue, q_count, aux_ready, hazard1, hazard2. Reset mid-operation discards all queued results. aux_ready is 0 during reset and 1 in the first cycle after reset.
- **Output register:** we/waddr/wdata are registered, so each write reaches the register file one edge after its selection. The register file forwards same-cycle writes, so there is no further bypass here.
- **Address zero:** a source with address 0 is a "real write" never. pipe_we with pipe_waddr=0 counts as idle. An auxiliary handshake to address 0 completes but is discarded (not enqueued).
- **Port priority, evaluated each edge in order:**
  1. Pipeline real write: output <= pipeline.
  2. Else, queue non-empty: output <= queue head, and the head is popped.
  3. Else, aux handshake with nonzero address: output <= aux directly. This is the bypass path, latency 1, and nothing is enqueued.
  4. Else: we <= 0; waddr and wdata hold their previous values.
- **Enqueue:** an aux handshake (aux_valid & aux_ready) with nonzero address is enqueued at the same edge unless it took the bypass path. Enqueue and pop in the same edge are allowed. count changes by +1, -1 or 0, and FIFO order is preserved.
- **aux_ready** = count < DEPTH, computed from the registered count only.
  - No combinational path from any input.
  - A full queue refuses even in a cycle in which it pops.
- **Pointers:** read/write pointers wrap modulo DEPTH. count saturates neither way; overflow and underflow are impossible by construction, and assertions are required.
- **Hazards:**
  - hazardN = 1 if chkN is nonzero and equals the waddr of any valid queue entry. Combinational.
  - The output register is excluded because of register-file forwarding.
  - An aux handshake in the current cycle is excluded, since decode issues the consuming instruction only after the aux unit's own busy flag clears.
- **Ordering contract:**
  - Upstream guarantees that no pipeline write targets an address present in the queue. Decode enforces this with the hazard flags.
  - The bench asserts this contract; the RTL does not repair it.
- **Starvation:** with continuous pipeline writes the queue never drains; this is accepted. The pipeline stalls on hazards, which eventually frees the port.

Decomposition:
- The existing shared defines file supplies RegBus, RegAddrBus, WriteEnable, WriteDisable, ZeroWord and RstEnable.
- Add a shared constant AuxQDepth (default 2).
- One sub-module, wb_aux_fifo: storage, pointers, count, head outputs and parallel entry-address/valid outputs used by the hazard compare.
- The arbiter holds the priority mux, the output register and the hazard comparators.

Test Plan:
1. **Reset, then idle:** release rst with no inputs -> we=0, aux_ready=1, q_count=0, hazards 0. Assert rst mid-queue holding 2 entries -> next cycle q_count=0 and no stale write ever appears.
2. **Bypass:** with the queue empty, a single aux handshake (addr 7, 0xDEADBEEF) while the pipeline is idle -> next edge we=1, waddr=7, wdata=0xDEADBEEF; q_count stays 0.
3. **Contention:**
   - Stimulus: pipe write (3, 0x11) in the same cycle as aux (9, 0x22); pipeline idle next cycle.
   - Required: edge1 output (3, 0x11) and q_count=1; hazard1=1 when chk_addr1=9. Edge2 output (9, 0x22), q_count=0, hazard1=0.
4. **Back-pressure:**
   - Stimulus: pipeline writes every cycle; aux offers (4, A), (5, B), (6, C).
   - Required: A and B are accepted; aux_ready=0 with C held. After the pipeline goes idle, outputs are 4 then 5, C is accepted, and 6 follows — FIFO order preserved.
5. **Address zero:**
   - Stimulus: pipe_we=1 with addr 0 while the queue holds (8, X); separately, aux (0, Y).
   - Required: the queue pops and outputs (8, X); the aux handshake completes with no write and no enqueue.
6. **Simultaneous push/pop at full:**
   - Stimulus: DEPTH=2 queue full, pipeline idle, aux_valid=1.
   - Required: pop occurs, aux_ready=0 that cycle (no enqueue), aux_ready=1 the following cycle.
